// File: rtl/ajuste_controller_multicampo_if.sv
// Bundle between the button/counter side and the multi-field adjust controller.
// Buttons and live values flow in; pause/load/select and edited values flow out.
interface ajuste_controller_multicampo_if #(
   parameter int N_CAMPOS = 3,
   parameter int LARGURA  = 6
);
   localparam int MODW = $clog2(N_CAMPOS + 1);

   logic                         btn_mode;
   logic                         btn_inc;
   logic                         btn_dec;
   logic                         btn_cancel;
   logic [N_CAMPOS*LARGURA-1:0]  valores_in;
   logic                         pause;
   logic                         load;
   logic [MODW-1:0]              modo_ajuste;
   logic [N_CAMPOS-1:0]          campo_ativo;
   logic [N_CAMPOS*LARGURA-1:0]  valores_out;

   modport master (
      output btn_mode, btn_inc, btn_dec, btn_cancel, valores_in,
      input  pause, load, modo_ajuste, campo_ativo, valores_out
   );

   modport slave (
      input  btn_mode, btn_inc, btn_dec, btn_cancel, valores_in,
      output pause, load, modo_ajuste, campo_ativo, valores_out
   );
endinterface

// File: rtl/ajuste_controller_multicampo.sv
// Multi-field clock adjust controller: captures N packed fields, edits them
// one at a time with inc/dec, auto-repeat, cancel and inactivity timeout.
module ajuste_controller_multicampo #(
   parameter int N_CAMPOS     = 3,
   parameter int LARGURA      = 6,
   parameter logic [N_CAMPOS*LARGURA-1:0] MAX_VALS = {6'd23, 6'd59, 6'd59},
   parameter int REPEAT_DELAY = 50_000_000,
   parameter int REPEAT_RATE  = 10_000_000,
   parameter int TIMEOUT      = 1_000_000_000
) (
   input  logic clk_100MHz,
   input  logic rst,
   ajuste_controller_multicampo_if.slave bus
);
   localparam int W    = N_CAMPOS * LARGURA;
   localparam int SELW = (N_CAMPOS > 1) ? $clog2(N_CAMPOS) : 1;
   localparam int MODW = $clog2(N_CAMPOS + 1);
   localparam int CW   = 32;

   typedef enum logic {NORMAL, AJUSTE} estado_t;

   estado_t         estado_q, estado_d;
   logic [SELW-1:0] sel_q, sel_d;
   logic [W-1:0]    val_q, val_d;
   logic [3:0]      prev_q;
   logic [CW-1:0]   rep_q, rep_d;
   logic            fase_q, fase_d;
   logic [CW-1:0]   to_q, to_d;

   logic [3:0]      btn, rise;
   logic            ambos, step_inc, step_dec;
   logic            timeout, load_c;
   logic [CW-1:0]   lim;
   logic [LARGURA-1:0] f, mx;

   assign btn   = {bus.btn_cancel, bus.btn_dec, bus.btn_inc, bus.btn_mode};
   assign rise  = btn & ~prev_q;
   assign ambos = bus.btn_inc & bus.btn_dec;

   // Auto-repeat: step on a rise, then after DELAY, then every RATE while held alone
   always_comb begin
      rep_d    = '0;
      fase_d   = 1'b0;
      step_inc = 1'b0;
      step_dec = 1'b0;
      lim      = fase_q ? CW'(REPEAT_RATE) : CW'(REPEAT_DELAY);
      if (estado_q == AJUSTE && !ambos) begin
         if (rise[1]) begin
            step_inc = 1'b1;
            rep_d    = CW'(1);
         end else if (rise[2]) begin
            step_dec = 1'b1;
            rep_d    = CW'(1);
         end else if ((bus.btn_inc || bus.btn_dec) && rep_q != '0) begin
            if (rep_q == lim) begin
               step_inc = bus.btn_inc;
               step_dec = bus.btn_dec;
               rep_d    = CW'(1);
               fase_d   = 1'b1;
            end else begin
               rep_d    = rep_q + CW'(1);
               fase_d   = fase_q;
            end
         end
      end
   end

   // Mode FSM: capture/clamp in NORMAL, field edits, exit paths and load pulse
   always_comb begin
      estado_d = estado_q;
      sel_d    = sel_q;
      val_d    = val_q;
      to_d     = '0;
      load_c   = 1'b0;
      timeout  = 1'b0;
      f        = '0;
      mx       = '0;
      unique case (estado_q)
         NORMAL: begin
            for (int i = 0; i < N_CAMPOS; i++) begin
               f  = bus.valores_in[i*LARGURA +: LARGURA];
               mx = MAX_VALS[i*LARGURA +: LARGURA];
               val_d[i*LARGURA +: LARGURA] = (f > mx) ? mx : f;
            end
            if (rise[0]) begin
               estado_d = AJUSTE;
               sel_d    = '0;
            end
         end
         AJUSTE: begin
            timeout = (to_q == CW'(TIMEOUT - 1)) && (rise == 4'b0000);
            to_d    = (rise != 4'b0000) ? '0 : to_q + CW'(1);
            if (rise[3] || timeout) begin
               estado_d = NORMAL;
               to_d     = '0;
            end else if (rise[0]) begin
               if (sel_q == SELW'(N_CAMPOS - 1)) begin
                  estado_d = NORMAL;
                  load_c   = 1'b1;
                  to_d     = '0;
               end else begin
                  sel_d = sel_q + SELW'(1);
               end
            end else if (step_inc || step_dec) begin
               for (int i = 0; i < N_CAMPOS; i++) begin
                  if (SELW'(i) == sel_q) begin
                     f  = val_q[i*LARGURA +: LARGURA];
                     mx = MAX_VALS[i*LARGURA +: LARGURA];
                     if (step_inc)
                        val_d[i*LARGURA +: LARGURA] = (f == mx) ? '0 : f + 1'b1;
                     else
                        val_d[i*LARGURA +: LARGURA] = (f == '0) ? mx : f - 1'b1;
                  end
               end
            end
         end
         default: estado_d = NORMAL;
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk_100MHz) begin
      if (rst) begin
         estado_q <= NORMAL;
         sel_q    <= '0;
         val_q    <= '0;
         prev_q   <= '0;
         rep_q    <= '0;
         fase_q   <= 1'b0;
         to_q     <= '0;
      end else begin
         estado_q <= estado_d;
         sel_q    <= sel_d;
         val_q    <= val_d;
         prev_q   <= btn;
         rep_q    <= rep_d;
         fase_q   <= fase_d;
         to_q     <= to_d;
      end
   end

   assign bus.pause       = (estado_q == AJUSTE);
   assign bus.load        = load_c & ~rst;
   assign bus.modo_ajuste = (estado_q == AJUSTE) ? MODW'(sel_q) + MODW'(1) : '0;
   assign bus.campo_ativo = (estado_q == AJUSTE) ? (N_CAMPOS'(1) << sel_q) : '0;
   assign bus.valores_out = val_q;
endmodule

// File: tb/tb_ajuste_controller_multicampo.sv
// Directed bench for the multi-field adjust controller.
// Short repeat/timeout parameters keep every scenario within a few hundred cycles.
module tb_ajuste_controller_multicampo;
   logic clk_100MHz = 1'b0;
   logic rst        = 1'b1;
   int   n_chk      = 0;
   int   n_fail     = 0;
   int   load_cnt   = 0;
   int   ld0;

   ajuste_controller_multicampo_if #(.N_CAMPOS(3), .LARGURA(6)) bus ();

   ajuste_controller_multicampo #(
      .N_CAMPOS(3), .LARGURA(6), .MAX_VALS({6'd23, 6'd59, 6'd59}),
      .REPEAT_DELAY(4), .REPEAT_RATE(2), .TIMEOUT(40)
   ) dut (
      .clk_100MHz(clk_100MHz),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   always @(negedge clk_100MHz) if (bus.load === 1'b1) load_cnt++;

   function automatic logic [17:0] pk(input int h, input int m, input int s);
      return {6'(h), 6'(m), 6'(s)};
   endfunction

   task automatic tick();
      @(posedge clk_100MHz);
      #1;
   endtask

   task automatic press(input int b);
      case (b)
         0: bus.btn_mode   = 1'b1;
         1: bus.btn_inc    = 1'b1;
         2: bus.btn_dec    = 1'b1;
         default: bus.btn_cancel = 1'b1;
      endcase
      tick();
      bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;
      bus.btn_dec  = 1'b0; bus.btn_cancel = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;
      bus.btn_dec  = 1'b0; bus.btn_cancel = 1'b0;
      bus.valores_in = pk(12, 34, 56);
      tick(); tick();
      n_chk++;
      if (bus.valores_out !== 18'd0 || bus.pause !== 1'b0 || bus.load !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outs got v=%h p=%b l=%b exp 0", bus.valores_out, bus.pause, bus.load);
      end
      rst = 1'b0;
      tick();
      n_chk++;
      if (bus.valores_out !== pk(12, 34, 56)) begin
         n_fail++;
         $display("FAIL reset_capture got=%h exp=%h", bus.valores_out, pk(12, 34, 56));
      end
      n_chk++;
      if (bus.pause !== 1'b0 || bus.modo_ajuste !== 2'd0 || bus.load !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_normal got p=%b m=%0d l=%b exp 0", bus.pause, bus.modo_ajuste, bus.load);
      end
   endtask

   task automatic test_edit_wrap();
      bus.valores_in = pk(23, 0, 58);
      press(0);
      n_chk++;
      if (bus.modo_ajuste !== 2'd1 || bus.campo_ativo !== 3'b001) begin
         n_fail++;
         $display("FAIL enter_f0 got m=%0d c=%b exp 1 001", bus.modo_ajuste, bus.campo_ativo);
      end
      press(1);
      n_chk++;
      if (bus.valores_out !== pk(23, 0, 59)) begin
         n_fail++;
         $display("FAIL inc_s59 got=%h exp=%h", bus.valores_out, pk(23, 0, 59));
      end
      press(1);
      n_chk++;
      if (bus.valores_out !== pk(23, 0, 0)) begin
         n_fail++;
         $display("FAIL inc_wrap got=%h exp=%h", bus.valores_out, pk(23, 0, 0));
      end
      press(0);
      n_chk++;
      if (bus.modo_ajuste !== 2'd2 || bus.campo_ativo !== 3'b010) begin
         n_fail++;
         $display("FAIL enter_f1 got m=%0d c=%b exp 2 010", bus.modo_ajuste, bus.campo_ativo);
      end
      press(2);
      n_chk++;
      if (bus.valores_out !== pk(23, 59, 0)) begin
         n_fail++;
         $display("FAIL dec_wrap got=%h exp=%h", bus.valores_out, pk(23, 59, 0));
      end
      press(0);
      press(1);
      n_chk++;
      if (bus.valores_out !== pk(0, 59, 0) || bus.campo_ativo !== 3'b100) begin
         n_fail++;
         $display("FAIL inc_h_wrap got=%h c=%b exp=%h", bus.valores_out, bus.campo_ativo, pk(0, 59, 0));
      end
      ld0 = load_cnt;
      bus.btn_mode = 1'b1;
      #1;
      n_chk++;
      if (bus.load !== 1'b1 || bus.valores_out !== pk(0, 59, 0) || bus.pause !== 1'b1) begin
         n_fail++;
         $display("FAIL load_cycle got l=%b v=%h p=%b exp 1 %h 1", bus.load, bus.valores_out, bus.pause, pk(0, 59, 0));
      end
      tick();
      bus.btn_mode = 1'b0;
      n_chk++;
      if (bus.load !== 1'b0 || bus.pause !== 1'b0) begin
         n_fail++;
         $display("FAIL after_load got l=%b p=%b exp 0 0", bus.load, bus.pause);
      end
      tick();
      n_chk++;
      if (load_cnt - ld0 !== 1) begin
         n_fail++;
         $display("FAIL load_width got=%0d exp=1", load_cnt - ld0);
      end
   endtask

   task automatic test_repeat();
      bus.valores_in = pk(5, 6, 10);
      press(0);
      bus.btn_inc = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      bus.btn_inc = 1'b0;
      tick();
      n_chk++;
      if (bus.valores_out !== pk(5, 6, 14)) begin
         n_fail++;
         $display("FAIL repeat_hold got=%h exp=%h", bus.valores_out, pk(5, 6, 14));
      end
      bus.btn_inc = 1'b1;
      bus.btn_dec = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      bus.btn_inc = 1'b0;
      bus.btn_dec = 1'b0;
      tick();
      n_chk++;
      if (bus.valores_out !== pk(5, 6, 14)) begin
         n_fail++;
         $display("FAIL both_held got=%h exp=%h", bus.valores_out, pk(5, 6, 14));
      end
      press(3);
      n_chk++;
      if (bus.pause !== 1'b0) begin
         n_fail++;
         $display("FAIL repeat_exit got p=%b exp 0", bus.pause);
      end
   endtask

   task automatic test_cancel();
      ld0 = load_cnt;
      bus.valores_in = pk(1, 2, 3);
      press(0);
      press(1);
      n_chk++;
      if (bus.valores_out !== pk(1, 2, 4)) begin
         n_fail++;
         $display("FAIL cancel_inc got=%h exp=%h", bus.valores_out, pk(1, 2, 4));
      end
      press(3);
      n_chk++;
      if (bus.pause !== 1'b0 || bus.modo_ajuste !== 2'd0 || bus.valores_out !== pk(1, 2, 3)) begin
         n_fail++;
         $display("FAIL cancel_exit got p=%b m=%0d v=%h exp 0 0 %h", bus.pause, bus.modo_ajuste, bus.valores_out, pk(1, 2, 3));
      end
      bus.valores_in = pk(1, 2, 9);
      tick();
      n_chk++;
      if (bus.valores_out !== pk(1, 2, 9)) begin
         n_fail++;
         $display("FAIL cancel_track got=%h exp=%h", bus.valores_out, pk(1, 2, 9));
      end
      n_chk++;
      if (load_cnt !== ld0) begin
         n_fail++;
         $display("FAIL cancel_noload got=%0d exp=%0d", load_cnt, ld0);
      end
   endtask

   task automatic test_timeout();
      ld0 = load_cnt;
      bus.valores_in = pk(0, 0, 0);
      press(0);
      for (int i = 0; i < 38; i++) tick();
      n_chk++;
      if (bus.pause !== 1'b1) begin
         n_fail++;
         $display("FAIL to_early got p=%b exp 1", bus.pause);
      end
      tick();
      n_chk++;
      if (bus.pause !== 1'b0 || load_cnt !== ld0) begin
         n_fail++;
         $display("FAIL to_fire got p=%b ld=%0d exp 0 %0d", bus.pause, load_cnt, ld0);
      end
      press(0);
      for (int i = 0; i < 38; i++) tick();
      bus.btn_inc = 1'b1;
      tick();
      bus.btn_inc = 1'b0;
      n_chk++;
      if (bus.pause !== 1'b1 || bus.valores_out !== pk(0, 0, 1)) begin
         n_fail++;
         $display("FAIL to_restart got p=%b v=%h exp 1 %h", bus.pause, bus.valores_out, pk(0, 0, 1));
      end
      for (int i = 0; i < 39; i++) tick();
      n_chk++;
      if (bus.pause !== 1'b1) begin
         n_fail++;
         $display("FAIL to_held got p=%b exp 1", bus.pause);
      end
      tick();
      n_chk++;
      if (bus.pause !== 1'b0 || load_cnt !== ld0) begin
         n_fail++;
         $display("FAIL to_fire2 got p=%b ld=%0d exp 0 %0d", bus.pause, load_cnt, ld0);
      end
   endtask

   task automatic test_reset_mid();
      bus.valores_in = pk(30, 63, 60);
      press(0);
      press(0);
      n_chk++;
      if (bus.modo_ajuste !== 2'd2) begin
         n_fail++;
         $display("FAIL mid_sel got=%0d exp=2", bus.modo_ajuste);
      end
      rst = 1'b1;
      tick();
      n_chk++;
      if (bus.pause !== 1'b0 || bus.load !== 1'b0 || bus.modo_ajuste !== 2'd0 ||
          bus.campo_ativo !== 3'b000 || bus.valores_out !== 18'd0) begin
         n_fail++;
         $display("FAIL mid_reset got p=%b l=%b m=%0d c=%b v=%h exp all 0",
                  bus.pause, bus.load, bus.modo_ajuste, bus.campo_ativo, bus.valores_out);
      end
      rst = 1'b0;
      tick();
      n_chk++;
      if (bus.valores_out !== pk(23, 59, 59)) begin
         n_fail++;
         $display("FAIL clamp got=%h exp=%h", bus.valores_out, pk(23, 59, 59));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_edit_wrap();
      test_repeat();
      test_cancel();
      test_timeout();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
